// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus: PC handshake, instruction-memory read port, flush and decoder-side queue head.
// slave = the fetch queue, master = its surroundings (PC logic, memory, decoder).
interface instr_fetch_queue_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned DEPTH   = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0]  pc_in;
  logic               pc_valid;
  logic               pc_ready;
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_rdata;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic [CNT_W-1:0]   count;

  modport slave (
    input  pc_in, pc_valid, mem_rdata, flush, out_ready,
    output pc_ready, mem_req, mem_addr, out_valid, out_instr, out_pc, count
  );

  modport master (
    output pc_in, pc_valid, mem_rdata, flush, out_ready,
    input  pc_ready, mem_req, mem_addr, out_valid, out_instr, out_pc, count
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Fetch stage: reads instruction memory at the current PC and queues {pc, instr} pairs
// for the decoder, reserving a slot per in-flight read so no response is ever dropped.
module instr_fetch_queue #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned DEPTH   = 4
) (
  input logic                clock,
  input logic                reset,
  instr_fetch_queue_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  entry_t             entry_q [DEPTH];
  entry_t             entry_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               inflight_q, inflight_d;
  logic [ADDR_W-1:0]  pending_pc_q, pending_pc_d;

  logic               out_valid_c;
  logic               pop_c;
  logic               write_c;
  logic               pc_ready_c;
  logic               accept_c;
  logic [OCC_W-1:0]   occupancy_c;

  // Occupancy counts the reserved in-flight slot; a pop this cycle frees one immediately.
  always_comb begin
    out_valid_c = (count_q != '0);
    pop_c       = out_valid_c && bus.out_ready;
    write_c     = inflight_q && !bus.flush;
    occupancy_c = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop_c);
    pc_ready_c  = !reset && !bus.flush && (occupancy_c < OCC_W'(DEPTH));
    accept_c    = bus.pc_valid && pc_ready_c;
  end

  // Next-state: flush clears everything and discards the response arriving this cycle.
  always_comb begin
    entry_d      = entry_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    inflight_d   = accept_c;
    pending_pc_d = pending_pc_q;

    if (accept_c) begin
      pending_pc_d = bus.pc_in;
    end

    if (bus.flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      inflight_d = 1'b0;
    end else begin
      if (write_c) begin
        entry_d[wr_ptr_q] = '{pc: pending_pc_q, instr: bus.mem_rdata};
        wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(write_c) - CNT_W'(pop_c);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      entry_q      <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      inflight_q   <= 1'b0;
      pending_pc_q <= '0;
    end else begin
      entry_q      <= entry_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      inflight_q   <= inflight_d;
      pending_pc_q <= pending_pc_d;
    end
  end

  // Memory-side handshake is combinational so the read issues in the accepting cycle.
  assign bus.pc_ready  = pc_ready_c;
  assign bus.mem_req   = accept_c;
  assign bus.mem_addr  = bus.pc_in;
  assign bus.out_valid = out_valid_c;
  assign bus.out_instr = entry_q[rd_ptr_q].instr;
  assign bus.out_pc    = entry_q[rd_ptr_q].pc;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed and randomised checks of instr_fetch_queue against a per-cycle queue model;
// the memory model returns 16'h1000 + address one cycle after each read strobe.
module tb_instr_fetch_queue;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned DEPTH   = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  instr_fetch_queue_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) bus ();

  instr_fetch_queue #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    bus.mem_rdata <= bus.mem_req ? (16'h1000 + {8'h00, bus.mem_addr}) : 16'hdead;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_q[$];
  logic       m_infl = 1'b0;
  logic [7:0] m_pend = 8'h00;
  int         reqs;
  int         nxt;
  int         maxc;
  logic [7:0] pc;
  logic [7:0] rpc;
  logic       r_pv, r_ordy, r_fl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check the settled outputs, then advance the model.
  task automatic step(input logic pv, input logic [7:0] pcv, input logic ordy, input logic fl);
    logic m_pop;
    logic m_rdy;
    int   occ;
    @(negedge clk);
    bus.pc_valid  = pv;
    bus.pc_in     = pcv;
    bus.out_ready = ordy;
    bus.flush     = fl;
    #1;
    m_pop = (m_q.size() != 0) && ordy;
    occ   = m_q.size() + int'(m_infl) - int'(m_pop);
    m_rdy = !fl && (occ < int'(DEPTH));
    chk("pc_ready", 32'(bus.pc_ready), 32'(m_rdy));
    chk("mem_req", 32'(bus.mem_req), 32'(pv && m_rdy));
    if (pv && m_rdy) chk("mem_addr", 32'(bus.mem_addr), 32'(pcv));
    chk("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
    chk("count", 32'(bus.count), 32'(m_q.size()));
    if (m_q.size() != 0) begin
      chk("out_pc", 32'(bus.out_pc), 32'(m_q[0]));
      chk("out_instr", 32'(bus.out_instr), 32'h1000 + 32'(m_q[0]));
    end
    if (bus.mem_req) reqs++;
    if (fl) begin
      m_q.delete();
      m_infl = 1'b0;
    end else begin
      if (m_infl) m_q.push_back(m_pend);
      if (m_pop) void'(m_q.pop_front());
      m_infl = pv && m_rdy;
      if (m_infl) m_pend = pcv;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.pc_valid  = 1'b0;
    bus.pc_in     = 8'h00;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;

    // Reset state, with a valid PC presented to prove mem_req stays low.
    #1;
    rst          = 1'b1;
    bus.pc_valid = 1'b1;
    bus.pc_in    = 8'h55;
    @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_out_pc", 32'(bus.out_pc), 32'd0);
    chk("rst_out_instr", 32'(bus.out_instr), 32'd0);
    @(negedge clk);
    rst          = 1'b0;
    bus.pc_valid = 1'b0;

    // T1: streaming fetch, two-cycle latency, decoder never stalls.
    step(1'b1, 8'd0, 1'b1, 1'b0);
    chk("t1_c0_mem_req", 32'(bus.mem_req), 32'd1);
    step(1'b1, 8'd1, 1'b1, 1'b0);
    chk("t1_c1_valid", 32'(bus.out_valid), 32'd0);
    step(1'b1, 8'd2, 1'b1, 1'b0);
    chk("t1_c2_pc", 32'(bus.out_pc), 32'd0);
    chk("t1_c2_instr", 32'(bus.out_instr), 32'h1000);
    step(1'b1, 8'd3, 1'b1, 1'b0);
    chk("t1_c3_pc", 32'(bus.out_pc), 32'd1);
    chk("t1_c3_instr", 32'(bus.out_instr), 32'h1001);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    chk("t1_c4_pc", 32'(bus.out_pc), 32'd2);
    chk("t1_c4_count", 32'(bus.count), 32'd1);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    chk("t1_c5_instr", 32'(bus.out_instr), 32'h1003);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    chk("t1_c6_valid", 32'(bus.out_valid), 32'd0);

    // T2: decoder stalled, PC always valid -> exactly DEPTH fetches, then back-pressure.
    reqs = 0;
    pc   = 8'd0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, pc, 1'b0, 1'b0);
      if (bus.mem_req) pc++;
    end
    chk("t2_reqs", 32'(reqs), 32'd4);
    chk("t2_count_full", 32'(bus.count), 32'd4);
    chk("t2_ready_low", 32'(bus.pc_ready), 32'd0);

    // T3: pop and fetch together while full, then drain; order 0..5 across pointer wrap.
    nxt = 0;
    for (int i = 0; i < 12; i++) begin
      step(pc < 8'd6, pc, 1'b1, 1'b0);
      if (i == 0) begin
        chk("t3_ready_full_pop", 32'(bus.pc_ready), 32'd1);
        chk("t3_count_full", 32'(bus.count), 32'd4);
      end
      if (bus.out_valid) begin
        chk("t3_order", 32'(bus.out_pc), 32'(nxt));
        nxt++;
      end
      if (bus.mem_req) pc++;
    end
    chk("t3_total", 32'(nxt), 32'd6);

    // T4: flush as the pc=7 response returns with two entries queued.
    step(1'b1, 8'd5, 1'b0, 1'b0);
    step(1'b1, 8'd6, 1'b0, 1'b0);
    step(1'b1, 8'd7, 1'b0, 1'b0);
    step(1'b1, 8'd8, 1'b0, 1'b1);
    chk("t4_queued", 32'(bus.count), 32'd2);
    chk("t4_flush_req", 32'(bus.mem_req), 32'd0);
    chk("t4_flush_ready", 32'(bus.pc_ready), 32'd0);
    step(1'b1, 8'd20, 1'b0, 1'b0);
    chk("t4_count0", 32'(bus.count), 32'd0);
    chk("t4_valid0", 32'(bus.out_valid), 32'd0);
    chk("t4_accept20", 32'(bus.mem_req), 32'd1);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    chk("t4_not_yet", 32'(bus.out_valid), 32'd0);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    chk("t4_pc20", 32'(bus.out_pc), 32'd20);
    chk("t4_instr20", 32'(bus.out_instr), 32'h1014);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    chk("t4_no_pc7", 32'(bus.out_valid), 32'd0);

    // T5: asynchronous reset mid-cycle with three entries and one fetch in flight.
    step(1'b1, 8'd30, 1'b0, 1'b0);
    step(1'b1, 8'd31, 1'b0, 1'b0);
    step(1'b1, 8'd32, 1'b0, 1'b0);
    step(1'b1, 8'd33, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    chk("t5_pre_count", 32'(bus.count), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_async_count", 32'(bus.count), 32'd0);
    chk("t5_async_pc", 32'(bus.out_pc), 32'd0);
    m_q.delete();
    m_infl = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'd0, 1'b1, 1'b0);
      chk("t5_no_stale", 32'(bus.out_valid), 32'd0);
    end
    step(1'b1, 8'd40, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    chk("t5_post_pc40", 32'(bus.out_pc), 32'd40);

    // T6: random traffic against the model.
    rpc  = 8'd100;
    maxc = 0;
    for (int i = 0; i < 10000; i++) begin
      r_pv   = ($urandom_range(0, 3) != 0);
      r_ordy = 1'($urandom_range(0, 1));
      r_fl   = ($urandom_range(0, 31) == 0);
      step(r_pv, rpc, r_ordy, r_fl);
      if (int'(bus.count) > maxc) maxc = int'(bus.count);
      if (bus.mem_req || !r_pv) rpc = 8'($urandom);
    end
    chk("t6_max_le_depth", 32'(maxc <= int'(DEPTH)), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
